// File: rtl/wb_bus_arbiter.sv
// Round-robin WISHBONE bus arbiter with per-grant watchdog.
// On a watchdog timeout the grant is revoked and a one-cycle error goes back to the stalled master.
module wb_bus_arbiter #(
    parameter int N_MASTERS      = 4,
    parameter int N_BITS_MASTER  = 2,
    parameter int N_BITS_TIMEOUT = 8,
    parameter int TIMEOUT_CYCLES = 200
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_MASTERS-1:0]     cyc_i,
    input  logic                     ACK_I,
    input  logic                     ERR_I,
    input  logic                     RTY_I,
    output logic [N_MASTERS-1:0]     gnt_o,
    output logic [N_BITS_MASTER-1:0] gnt_id_o,
    output logic                     bus_busy_o,
    output logic [N_MASTERS-1:0]     timeout_err_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_TO_WAIT
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [N_MASTERS-1:0]      r_gnt;
    logic [N_MASTERS-1:0]      w_gnt_nxt;
    logic [N_BITS_MASTER-1:0]  r_gnt_id;
    logic [N_BITS_MASTER-1:0]  w_gnt_id_nxt;
    logic [N_BITS_TIMEOUT-1:0] r_cnt;
    logic [N_BITS_TIMEOUT-1:0] w_cnt_nxt;
    logic [N_BITS_MASTER-1:0]  r_last;
    logic [N_BITS_MASTER-1:0]  w_last_nxt;
    logic [N_MASTERS-1:0]      r_err;
    logic [N_MASTERS-1:0]      w_err_nxt;

    logic                      w_term;
    logic                      w_expire;
    logic                      w_found;
    logic [N_BITS_MASTER-1:0]  w_pick;
    logic [N_BITS_MASTER-1:0]  w_idx_b;
    int unsigned               w_idx;

    assign w_term   = ACK_I | ERR_I | RTY_I;
    assign w_expire = (r_cnt == N_BITS_TIMEOUT'(TIMEOUT_CYCLES - 1));

    // Circular search starting one past the last owner; first hit wins.
    always_comb begin : rr_pick
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = 0;
        w_idx_b = '0;
        for (int unsigned k = 1; k <= N_MASTERS; k++) begin
            w_idx = k + {{(32-N_BITS_MASTER){1'b0}}, r_last};
            if (w_idx >= N_MASTERS) begin
                w_idx = w_idx - N_MASTERS;
            end
            w_idx_b = w_idx[N_BITS_MASTER-1:0];
            if (!w_found && cyc_i[w_idx_b]) begin
                w_found = 1'b1;
                w_pick  = w_idx_b;
            end
        end
    end

    always_comb begin : fsm_next
        w_state_nxt  = r_state;
        w_gnt_nxt    = r_gnt;
        w_gnt_id_nxt = r_gnt_id;
        w_cnt_nxt    = r_cnt;
        w_last_nxt   = r_last;
        w_err_nxt    = '0;
        case (r_state)
            S_IDLE: begin
                w_gnt_nxt = '0;
                if (w_found) begin
                    w_gnt_nxt[w_pick] = 1'b1;
                    w_gnt_id_nxt      = w_pick;
                    w_cnt_nxt         = '0;
                    w_state_nxt       = S_GRANT;
                end
            end
            S_GRANT: begin
                if (w_term) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt != '1) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
                // Release takes precedence over expiry; a termination suppresses expiry.
                if (!cyc_i[r_gnt_id]) begin
                    w_gnt_nxt   = '0;
                    w_last_nxt  = r_gnt_id;
                    w_state_nxt = S_IDLE;
                end else if (w_expire && !w_term) begin
                    w_gnt_nxt           = '0;
                    w_err_nxt[r_gnt_id] = 1'b1;
                    w_last_nxt          = r_gnt_id;
                    w_state_nxt         = S_TO_WAIT;
                end
            end
            S_TO_WAIT: begin
                w_gnt_nxt = '0;
                if (!cyc_i[r_last]) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_gnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_gnt    <= '0;
            r_gnt_id <= '0;
            r_cnt    <= '0;
            r_last   <= N_BITS_MASTER'(N_MASTERS - 1);
            r_err    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_gnt    <= w_gnt_nxt;
            r_gnt_id <= w_gnt_id_nxt;
            r_cnt    <= w_cnt_nxt;
            r_last   <= w_last_nxt;
            r_err    <= w_err_nxt;
        end
    end

    assign gnt_o         = r_gnt;
    assign gnt_id_o      = r_gnt_id;
    assign bus_busy_o    = (r_state == S_GRANT);
    assign timeout_err_o = r_err;

endmodule

// File: doc/wb_bus_arbiter.md
# wb_bus_arbiter

Round-robin WISHBONE bus arbiter that shares the NIC's WB bus between the noc2wb master path and up to N_MASTERS-1 other masters, such as the local processing element and DMA. It drives the one-hot gnt_wb_i inputs of the masters and the mux-select index for the shared address, data and control lines. It supervises each granted cycle with a watchdog. On a watchdog timeout it revokes the grant and returns a one-cycle error to the stuck master.

## Interface
- N_MASTERS, 4, number of requesting masters (≥2); master 0 is the noc2wb path
- N_BITS_MASTER, 2, clog2(N_MASTERS)
- N_BITS_TIMEOUT, 8, width of the watchdog counter
- TIMEOUT_CYCLES, 200, maximum cycles a grant may run without a bus termination; range 2 to 2^N_BITS_TIMEOUT-1
- clk  in  1  system clock, all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- cyc_i  in  N_MASTERS  CYC_O of each master; bit i high means master i requests or holds the bus
- ACK_I  in  1  shared slave ACK
- ERR_I  in  1  shared slave ERR
- RTY_I  in  1  shared slave RTY
- gnt_o  out  N_MASTERS  one-hot grant, bit i wired to gnt_wb_i of master i; registered
- gnt_id_o  out  N_BITS_MASTER  index of the current or most recent owner, used as the bus mux select; registered
- bus_busy_o  out  1  high while state is GRANT
- timeout_err_o  out  N_MASTERS  one-hot, one-cycle error pulse, ORed into the offending master's ERR_I

## Operation
- Three states: IDLE, GRANT, TO_WAIT.
- The round-robin pointer last_r holds the index of the last owner. Reset value is N_MASTERS-1, so master 0 wins first after reset.

IDLE
- If any bit of cyc_i is high, select the first requester, searching circularly from last_r+1.
- On the next edge: gnt_o takes that bit, gnt_id_o takes its index, the watchdog counter clears to 0, and the state moves to GRANT.
- If no bit of cyc_i is high, stay in IDLE with gnt_o = 0.

GRANT
- A termination is ACK_I, ERR_I or RTY_I high.
- On a termination, clear the counter to 0. Otherwise increment it, saturating at all-ones.
- If cyc_i[owner] is low, deassert gnt_o on the next edge, set last_r to the owner, and move to IDLE.
- Else if the counter equals TIMEOUT_CYCLES-1 and there is no termination this cycle, do the following on the next edge:
  - clear gnt_o;
  - pulse timeout_err_o[owner] for exactly one cycle;
  - set last_r to the owner;
  - move to TO_WAIT.

TO_WAIT
- gnt_o stays 0.
- Remain in TO_WAIT until cyc_i[last_r] is low, then move to IDLE on the next edge.
- Other requesters are not served during TO_WAIT. This prevents a stuck master from re-acquiring the bus before it has released CYC.

Control and priority rules
- Requests from non-owners never affect GRANT; there is no preemption.
- Simultaneous events in GRANT:
  - CYC drop together with counter expiry: the release wins, with no error pulse.
  - Termination together with counter expiry: the termination wins, the counter clears and the grant continues.
- Master 0 receives no priority beyond the reset pointer value.
- gnt_id_o changes only when a new grant is issued. It holds its value in IDLE and TO_WAIT so the bus mux stays stable.

## Timing
- Reset values: all outputs are 0, the state is IDLE, the counter is 0, and last_r is N_MASTERS-1.
- rst asserted in any state, including mid-burst, returns everything to these values on the next edge. The master is expected to abort its own cycle on reset.
- Grant latency: with cyc_i[i] rising in cycle n while IDLE, gnt_o[i] is high in cycle n+1.
- Release latency: with cyc_i[owner] low in cycle m, gnt_o is 0 in cycle m+1.
  - The earliest next grant is in cycle m+2, which guarantees at least one dead cycle between owners.
- Timeout: with gnt_o first high in cycle g and no termination afterwards:
  - gnt_o stays high for cycles g through g+TIMEOUT_CYCLES-1;
  - in cycle g+TIMEOUT_CYCLES, gnt_o is 0 and timeout_err_o[owner] is 1;
  - in cycle g+TIMEOUT_CYCLES+1, timeout_err_o is 0 again.
- Any termination in cycle t restarts the window, so expiry can occur no earlier than cycle t+TIMEOUT_CYCLES.
- At most one bit of gnt_o and at most one bit of timeout_err_o is high in any cycle.
- gnt_o and timeout_err_o are never high in the same cycle.

## Test plan
- Reset, then cyc_i=4'b0001 at cycle 5 -> gnt_o=0001 and gnt_id_o=0 at cycle 6; cyc_i=0 at cycle 10 -> gnt_o=0 at cycle 11, bus_busy_o=0.
- cyc_i=4'b1111 held, each owner dropping CYC for 1 cycle after 3 ACKs -> grant order 0,1,2,3,0 with exactly one gnt_o=0 cycle between owners.
- Master 2 granted with ACK_I pulsing every 150 cycles for 1000 cycles (TIMEOUT_CYCLES=200) -> no timeout_err_o pulse; gnt_o[2] continuous.
- Master 1 granted at cycle g with no termination -> gnt_o=0 and timeout_err_o=0010 at g+200, pulse width 1; master 3 requesting is not granted until cyc_i[1] falls, then receives the grant 2 cycles later.
- Counter expiry cycle coinciding with ACK_I=1 -> no error and the grant continues; expiry coinciding with cyc_i[owner]=0 -> normal release with no error.
- rst asserted mid-grant while cyc_i=1111 -> all outputs 0 next cycle; after rst is released, master 0 is granted first.
